// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: the imem request/response pair, the decode handshake,
// the execute redirect and the queue occupancy.
interface instr_fetch_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 2
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] imem_addr_o;
    logic                  imem_req_o;
    logic [DATA_WIDTH-1:0] imem_instr_i;
    logic                  if_valid_o;
    logic                  if_ready_i;
    logic [DATA_WIDTH-1:0] if_instr_o;
    logic [DATA_WIDTH-1:0] if_pc_o;
    logic                  redirect_i;
    logic [DATA_WIDTH-1:0] redirect_pc_i;
    logic [CNT_W-1:0]      queue_count_o;

    // The fetch unit itself
    modport master (
        output imem_addr_o, imem_req_o, if_valid_o, if_instr_o, if_pc_o, queue_count_o,
        input  imem_instr_i, if_ready_i, redirect_i, redirect_pc_i
    );

    // Its surroundings: imem, decode and execute
    modport slave (
        input  imem_addr_o, imem_req_o, if_valid_o, if_instr_o, if_pc_o, queue_count_o,
        output imem_instr_i, if_ready_i, redirect_i, redirect_pc_i
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register driving a combinational imem, plus a small FIFO of
// {pc, instr} pairs handed to decode over valid/ready, flushed on redirect.
module instr_fetch #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    QUEUE_DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);
    localparam int                PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int                CNT_W   = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(QUEUE_DEPTH);

    function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] addr);
        return addr & ~DATA_WIDTH'(3);
    endfunction

    // Wraps silently at the top of the address space
    function automatic logic [DATA_WIDTH-1:0] next_pc(input logic [DATA_WIDTH-1:0] pc);
        return pc + DATA_WIDTH'(4);
    endfunction

    logic [DATA_WIDTH-1:0] pc_p0;
    logic                  push_p0;

    logic [DATA_WIDTH-1:0] pc_mem    [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] hold_pc_p1;
    logic [DATA_WIDTH-1:0] hold_instr_p1;
    logic                  empty;
    logic                  full;
    logic                  vld_p1;
    logic                  pop_p1;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    // ---- p1: queue head toward decode; a redirect hides it the same cycle ----
    assign vld_p1 = !empty && !bus.redirect_i;
    assign pop_p1 = vld_p1 && bus.if_ready_i;

    // ---- p0: fetch request; a full queue still accepts when its head leaves ----
    assign push_p0 = !rst && !bus.redirect_i && (!full || pop_p1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_p0         <= RESET_PC;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            hold_pc_p1    <= '0;
            hold_instr_p1 <= '0;
        end else if (bus.redirect_i) begin
            pc_p0  <= word_align(bus.redirect_pc_i);
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_p0) begin
                pc_p0  <= next_pc(pc_p0);
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_p1) begin
                rd_ptr        <= rd_ptr + PTR_W'(1);
                hold_pc_p1    <= pc_mem[rd_ptr];
                hold_instr_p1 <= instr_mem[rd_ptr];
            end
            case ({push_p0, pop_p1})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is only ever read while count says the slot is live, so it carries no reset
    always_ff @(posedge clk) begin
        if (push_p0) begin
            pc_mem[wr_ptr]    <= pc_p0;
            instr_mem[wr_ptr] <= bus.imem_instr_i;
        end
    end

    assign bus.imem_addr_o   = pc_p0;
    assign bus.imem_req_o    = push_p0;
    assign bus.if_valid_o    = vld_p1;
    assign bus.if_pc_o       = empty ? hold_pc_p1    : pc_mem[rd_ptr];
    assign bus.if_instr_o    = empty ? hold_instr_p1 : instr_mem[rd_ptr];
    assign bus.queue_count_o = count;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed literal checks plus randomized ready/redirect/reset
// traffic compared every cycle against a queue-based reference model.
module tb_instr_fetch;
    localparam int          DW   = 32;
    localparam int          QD   = 2;
    localparam logic [31:0] RPC0 = 32'h0000_0000;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_fetch_if #(.DATA_WIDTH(DW), .QUEUE_DEPTH(QD)) ifc0 ();
    instr_fetch_if #(.DATA_WIDTH(DW), .QUEUE_DEPTH(QD)) ifc1 ();

    instr_fetch #(.DATA_WIDTH(DW), .RESET_PC(RPC0), .QUEUE_DEPTH(QD)) dut0 (
        .clk(clk), .rst(rst), .bus(ifc0)
    );
    instr_fetch #(.DATA_WIDTH(DW), .RESET_PC(RPC1), .QUEUE_DEPTH(QD)) dut1 (
        .clk(clk), .rst(rst), .bus(ifc1)
    );

    always #5 clk = ~clk;

    // imem holds 0x100 + word index at every word address
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return 32'h100 + (a >> 2);
    endfunction

    assign ifc0.imem_instr_i  = imem_word(ifc0.imem_addr_o);
    assign ifc1.imem_instr_i  = imem_word(ifc1.imem_addr_o);
    assign ifc1.if_ready_i    = 1'b1;
    assign ifc1.redirect_i    = 1'b0;
    assign ifc1.redirect_pc_i = '0;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of {pc, instr} and a fetch address
    logic [63:0] mq[$];
    logic [31:0] mpc = RPC0;
    bit          pend = 0;
    bit          p_redir, p_push, p_pop;
    logic [31:0] p_rpc;
    logic [63:0] p_word;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            mpc  = RPC0;
            pend = 0;
            chk("m_rst_valid", ifc0.if_valid_o, 0);
            chk("m_rst_req", ifc0.imem_req_o, 0);
            chk("m_rst_addr", ifc0.imem_addr_o, RPC0);
            chk("m_rst_count", ifc0.queue_count_o, 0);
        end else begin
            bit ev, epop, ereq;
            ev   = (mq.size() != 0) && !ifc0.redirect_i;
            epop = ev && ifc0.if_ready_i;
            ereq = !ifc0.redirect_i && ((mq.size() < QD) || epop);
            chk("m_valid", ifc0.if_valid_o, ev);
            chk("m_req", ifc0.imem_req_o, ereq);
            chk("m_addr", ifc0.imem_addr_o, mpc);
            chk("m_count", ifc0.queue_count_o, mq.size());
            if (ev) begin
                chk("m_head_pc", ifc0.if_pc_o, mq[0][63:32]);
                chk("m_head_instr", ifc0.if_instr_o, mq[0][31:0]);
            end
            p_redir = ifc0.redirect_i;
            p_rpc   = ifc0.redirect_pc_i;
            p_push  = ereq;
            p_pop   = epop;
            p_word  = {mpc, imem_word(mpc)};
            pend    = 1;
        end
    end

    always @(posedge clk) begin
        if (pend) begin
            if (p_redir) begin
                mq.delete();
                mpc = {p_rpc[31:2], 2'b00};
            end else begin
                if (p_pop) void'(mq.pop_front());
                if (p_push) begin
                    mq.push_back(p_word);
                    mpc = mpc + 32'd4;
                end
            end
            pend = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp5 [4];

    initial begin
        exp5[0] = 32'hFFFF_FFF8;
        exp5[1] = 32'hFFFF_FFFC;
        exp5[2] = 32'h0000_0000;
        exp5[3] = 32'h0000_0004;
        ifc0.if_ready_i    = 1'b1;
        ifc0.redirect_i    = 1'b0;
        ifc0.redirect_pc_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        chk("rst_valid", ifc0.if_valid_o, 0);
        chk("rst_req", ifc0.imem_req_o, 0);
        chk("rst_addr", ifc0.imem_addr_o, 32'h0);
        chk("rst_instr", ifc0.if_instr_o, 32'h0);
        chk("rst_pc", ifc0.if_pc_o, 32'h0);
        chk("rst_addr_hi", ifc1.imem_addr_o, 32'hFFFF_FFF8);

        // Streaming with ready high, and the wrapping PC on dut1
        tick();
        rst = 1'b0;
        #2;
        chk("s_c0_valid", ifc0.if_valid_o, 0);
        chk("s_c0_req", ifc0.imem_req_o, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            #2;
            chk("s_valid", ifc0.if_valid_o, 1);
            chk("s_pc", ifc0.if_pc_o, 32'(4 * (k - 1)));
            chk("s_instr", ifc0.if_instr_o, 32'(32'h100 + k - 1));
            chk("wrap_pc", ifc1.if_pc_o, exp5[k-1]);
        end

        // Asynchronous reset mid-cycle, then backpressure
        tick();
        rst = 1'b1;
        #1;
        chk("arst_valid", ifc0.if_valid_o, 0);
        chk("arst_req", ifc0.imem_req_o, 0);
        chk("arst_addr", ifc0.imem_addr_o, 32'h0);
        chk("arst_count", ifc0.queue_count_o, 0);
        chk("arst_pc", ifc0.if_pc_o, 32'h0);
        ifc0.if_ready_i = 1'b0;
        tick();
        rst = 1'b0;
        #2;
        chk("bp_c0_count", ifc0.queue_count_o, 0);
        tick();
        #2;
        chk("bp_c1_count", ifc0.queue_count_o, 1);
        chk("bp_c1_pc", ifc0.if_pc_o, 32'h0);
        chk("bp_c1_addr", ifc0.imem_addr_o, 32'h4);
        for (int k = 0; k < 4; k++) begin
            tick();
            #2;
            chk("bp_full_count", ifc0.queue_count_o, 2);
            chk("bp_full_req", ifc0.imem_req_o, 0);
            chk("bp_full_addr", ifc0.imem_addr_o, 32'h8);
        end
        tick();
        ifc0.if_ready_i = 1'b1;
        #2;
        chk("fp_req", ifc0.imem_req_o, 1);
        chk("fp_pc", ifc0.if_pc_o, 32'h0);
        tick();
        #2;
        chk("fp_count", ifc0.queue_count_o, 2);
        chk("fp_pc1", ifc0.if_pc_o, 32'h4);
        chk("fp_instr1", ifc0.if_instr_o, 32'h101);
        tick();
        #2;
        chk("fp_pc2", ifc0.if_pc_o, 32'h8);

        // Redirect while the queue holds 0x8, 0xC
        ifc0.redirect_i    = 1'b1;
        ifc0.redirect_pc_i = 32'h40;
        #1;
        chk("rd_valid", ifc0.if_valid_o, 0);
        chk("rd_req", ifc0.imem_req_o, 0);
        tick();
        ifc0.redirect_i = 1'b0;
        #2;
        chk("rd_addr", ifc0.imem_addr_o, 32'h40);
        chk("rd_count", ifc0.queue_count_o, 0);
        tick();
        #2;
        chk("rd_head_pc", ifc0.if_pc_o, 32'h40);
        chk("rd_head_instr", ifc0.if_instr_o, 32'h110);

        // Unaligned target, held redirect, last one wins
        tick();
        ifc0.redirect_i    = 1'b1;
        ifc0.redirect_pc_i = 32'h43;
        tick();
        #2;
        chk("ua_addr", ifc0.imem_addr_o, 32'h40);
        chk("ua_valid", ifc0.if_valid_o, 0);
        tick();
        tick();
        ifc0.redirect_pc_i = 32'h80;
        tick();
        ifc0.redirect_i = 1'b0;
        #2;
        chk("bb_addr", ifc0.imem_addr_o, 32'h80);
        chk("bb_req", ifc0.imem_req_o, 1);
        tick();
        #2;
        chk("bb_head_pc", ifc0.if_pc_o, 32'h80);
        chk("bb_head_instr", ifc0.if_instr_o, 32'h120);

        // Random traffic against the model
        for (int c = 0; c < 10000; c++) begin
            tick();
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                #1;
                chk("rr_valid", ifc0.if_valid_o, 0);
                chk("rr_req", ifc0.imem_req_o, 0);
                chk("rr_addr", ifc0.imem_addr_o, RPC0);
                tick();
                rst = 1'b0;
            end
            ifc0.if_ready_i    = ($urandom_range(0, 1) == 1);
            ifc0.redirect_i    = ($urandom_range(0, 15) == 0);
            ifc0.redirect_pc_i = $urandom;
        end
        tick();
        ifc0.redirect_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
